// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
//   Shared RV32I constants for the memory-access stage and its helpers:
//   - major opcodes, including the load/store opcodes that start a memory access
//   - funct3 size/sign encodings for loads and stores
//   - store lane helpers (byte enables, replicated write data) and a
//     misalignment predicate used when MEM_MISALIGN_TRAP_EN is defined
package mem_access_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the datum across lanes lets the byte enables pick the target lane.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_access_stage_load_align
//   Combinational load formatter: selects the byte/halfword addressed by the
//   low address bits out of a read word and sign/zero extends it.
//   Ports:
//     rdata_i  [XLEN]  word returned by data memory
//     a_i      [2]     address bits [1:0] of the access
//     funct3_i [3]     load size/sign (LB/LH/LW/LBU/LHU; others act as LW)
//     data_o   [XLEN]  formatted writeback value
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      a_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] byte_sh_s;
  logic [XLEN-1:0] half_sh_s;

  // Shift the addressed lane to bit 0, then extend according to funct3.
  always_comb begin
    byte_sh_s = rdata_i >> {a_i, 3'b000};
    // Halfword select ignores a[0]: misaligned halves fall back to the aligned one.
    half_sh_s = rdata_i >> {a_i[1], 4'b0000};
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sh_s[7]}}, byte_sh_s[7:0]};
      F3_LH:   data_o = {{(XLEN-16){half_sh_s[15]}}, half_sh_s[15:0]};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sh_s[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sh_s[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   RV32I memory-access stage between execute and writeback. Non-memory
//   instructions pass through with one cycle of latency; loads/stores issue a
//   held request on the data-memory bus and stall execute until ack.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     i_valid / o_ready               execute handshake (o_ready = IDLE)
//     i_opcode, i_funct3, i_rd        instruction fields
//     i_alu_result, i_rs2_data        address/result and store data
//     o_dmem_req/we/addr/wdata/be     data-memory request (held until ack)
//     i_dmem_ack, i_dmem_rdata        single-cycle completion and read data
//     o_valid, o_wb_data, o_opcode, o_rd  registered writeback bundle
//   Optional: define MEM_MISALIGN_TRAP_EN to add o_misalign and turn
//   misaligned half/word accesses into a flagged, memory-less completion.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [4:0]        i_rd,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_wdata,
  output logic [3:0]        o_dmem_be,
  input  logic              i_dmem_ack,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [6:0]        o_opcode,
  output logic [4:0]        o_rd
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic             o_misalign
`endif
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  logic              state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        a_q, a_d;
  logic              is_mem_s, is_store_s, mis_s;
  logic [XLEN-1:0]   load_data_s;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
`endif

  mem_access_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (i_dmem_rdata),
    .a_i      (a_q),
    .funct3_i (funct3_q),
    .data_o   (load_data_s)
  );

  // Decode of the incoming instruction.
  always_comb begin
    is_store_s = (i_opcode == OPC_STORE);
    is_mem_s   = (i_opcode == OPC_LOAD) || is_store_s;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_s      = is_mem_s && is_misaligned(i_funct3, i_alu_result[1:0]);
`else
    mis_s      = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE only for an aligned (or masked) memory op.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && is_mem_s && !mis_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_dmem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered bus and writeback bundle.
  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    valid_d   = 1'b0;
    wb_data_d = wb_data_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid && is_mem_s && !mis_s) begin
          req_d    = 1'b1;
          we_d     = is_store_s;
          addr_d   = {i_alu_result[ADDR_W-1:2], 2'b00};
          be_d     = is_store_s ? store_be(i_funct3, i_alu_result[1:0]) : 4'b1111;
          wdata_d  = is_store_s ? store_wdata(i_funct3, i_rs2_data) : {XLEN{1'b0}};
          opcode_d = i_opcode;
          rd_d     = i_rd;
          funct3_d = i_funct3;
          a_d      = i_alu_result[1:0];
        end else if (i_valid) begin
          // Pass-through, or a trapped misaligned access completing without memory.
          valid_d   = 1'b1;
          wb_data_d = mis_s ? {XLEN{1'b0}} : i_alu_result;
          opcode_d  = i_opcode;
          rd_d      = i_rd;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = mis_s;
`endif
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_dmem_ack) begin
          req_d     = 1'b0;
          valid_d   = 1'b1;
          // Stores still report completion so writeback can see the opcode.
          wb_data_d = we_q ? {XLEN{1'b0}} : load_data_s;
        end else begin
          req_d = 1'b1;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  // Datapath registers; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {XLEN{1'b0}};
      be_q      <= 4'b0000;
      valid_q   <= 1'b0;
      wb_data_q <= {XLEN{1'b0}};
      opcode_q  <= 7'd0;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      a_q       <= 2'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      a_q       <= a_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Port mapping; o_ready is the only output decoded from state.
  always_comb begin
    o_ready      = (state_q == ST_IDLE);
    o_dmem_req   = req_q;
    o_dmem_we    = we_q;
    o_dmem_addr  = addr_q;
    o_dmem_wdata = wdata_q;
    o_dmem_be    = be_q;
    o_valid      = valid_q;
    o_wb_data    = wb_data_q;
    o_opcode     = opcode_q;
    o_rd         = rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    o_misalign   = misalign_q;
`endif
  end

endmodule
